// File: rtl/restoring_div_ctrl.sv
// Control FSM for a restoring divider: sequences load, then ITER shift/subtract/test
// iterations on an external A:Q/M datapath, with a watchdog against a missing counter carry.
module restoring_div_ctrl #(
  parameter int unsigned ITER = 8,
  parameter int unsigned CW   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic a_neg,
  input  logic cnt_co,
  output logic ready,
  output logic done,
  output logic err,
  output logic cnt_init,
  output logic cnt_en,
  output logic ld,
  output logic sh,
  output logic sub,
  output logic rest,
  output logic qset
);

  localparam int unsigned WD_LAST = ITER - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wcnt;
  logic          accept;
  logic          wd_fire;
  logic          busy;

  assign accept  = (state == S_IDLE) && start;
  assign busy    = (state == S_LOAD) || (state == S_SHIFT) || (state == S_SUB) || (state == S_TEST);
  // Watchdog trips on the last allowed TEST when the counter never raised its carry.
  assign wd_fire = (state == S_TEST) && !cnt_co && (wcnt == CW'(WD_LAST));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort overrides every in-flight transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_SUB;
      S_SUB:   state_nxt = S_TEST;
      S_TEST:  state_nxt = (cnt_co || wd_fire) ? S_DONE : S_SHIFT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && busy) state_nxt = S_IDLE;
  end

  // Watchdog iteration count and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else if (state == S_TEST) begin
      wcnt <= wcnt + CW'(1);
      if (wd_fire && !abort) err <= 1'b1;
    end
  end

  // Output decode: Moore strobes, with rest/qset steered by a_neg in TEST
  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    cnt_init = 1'b0;
    cnt_en   = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    sub      = 1'b0;
    rest     = 1'b0;
    qset     = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_LOAD: begin
        ld       = 1'b1;
        cnt_init = 1'b1;
      end
      S_SHIFT: sh = 1'b1;
      S_SUB:   sub = 1'b1;
      S_TEST: begin
        cnt_en = 1'b1;
        rest   = a_neg;
        qset   = !a_neg;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Bench for restoring_div_ctrl: mod-8 counter, behavioural 8-bit A:Q/M datapath,
// scoreboard of expected quotient/remainder/err/latency popped on each done pulse.
module tb_restoring_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic a_neg, cnt_co;
  logic ready, done, err, cnt_init, cnt_en, ld, sh, sub, rest, qset;

  logic [2:0] cnt;
  logic       co_kill = 1'b0;
  logic [8:0] a;
  logic [7:0] q, m;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor  = 8'd1;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         e0;
  } exp_t;
  exp_t sb[$];

  logic [2:0] prev = 3'd0;
  logic       prev_abort = 1'b0;
  logic [2:0] code;
  logic [7:0] qtrace = 8'd0;
  logic       gap_on = 1'b0;
  int         gap = 0;
  int         last_gap = -1;

  always #5 clk = ~clk;

  restoring_div_ctrl #(.ITER(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a_neg(a_neg), .cnt_co(cnt_co),
    .ready(ready), .done(done), .err(err), .cnt_init(cnt_init), .cnt_en(cnt_en),
    .ld(ld), .sh(sh), .sub(sub), .rest(rest), .qset(qset)
  );

  assign a_neg  = a[8];
  assign cnt_co = !co_kill && (cnt == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= 3'd0;
    else if (cnt_init) cnt <= 3'd0;
    else if (cnt_en)   cnt <= cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (ld) begin
      a <= 9'd0;
      q <= dividend;
      m <= divisor;
    end else if (sh) begin
      a <= {a[7:0], q[7]};
      q <= {q[6:0], 1'b0};
    end else if (sub) begin
      a <= a - {1'b0, m};
    end else if (rest) begin
      a <= a + {1'b0, m};
    end else if (qset) begin
      q[0] <= 1'b1;
    end
  end

  always_ff @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: strobe sequencing, TEST steering, scoreboard push/pop
  always @(negedge clk) begin
    if (rst) begin
      code = ld ? 3'd1 : sh ? 3'd2 : sub ? 3'd3 : (rest || qset) ? 3'd4 : 3'd0;
      check("cnt_en", 32'(cnt_en), 32'(code == 3'd4));
      if (code != 3'd0) begin
        check("onehot", 32'($countones({ld, sh, sub, rest, qset}) <= 1), 32'd1);
        check("seq", 32'((code == 3'd1 && prev == 3'd0) ||
                         (code == 3'd2 && (prev == 3'd1 || prev == 3'd4)) ||
                         (code == 3'd3 && prev == 3'd2) ||
                         (code == 3'd4 && prev == 3'd3)), 32'd1);
      end
      if (ld) begin
        check("cnt_init", 32'(cnt_init), 32'd1);
        qtrace = 8'd0;
        if (gap_on) begin
          last_gap = gap;
          gap_on   = 1'b0;
        end
      end
      if (prev == 3'd3 && !prev_abort) begin
        check("rest", 32'(rest), 32'(a_neg));
        check("qset", 32'(qset), 32'(!a_neg));
        qtrace = {qtrace[6:0], qset};
      end
      if (gap_on && ready) gap++;
      if (ready && start) begin
        sb.push_back('{q: dividend / divisor, r: dividend % divisor, e: co_kill, e0: ecnt + 1});
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", 32'(ecnt - e.e0), 32'd25);
          check("quot", 32'(q), 32'(e.q));
          check("rem", 32'(a), 32'(e.r));
          check("qtrace", 32'(qtrace), 32'(e.q));
          check("err", 32'(err), 32'(e.e));
        end
        gap_on = 1'b1;
        gap    = 0;
      end
      prev       = code;
      prev_abort = abort;
    end else begin
      prev       = 3'd0;
      prev_abort = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (!(ready && sb.size() == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ready && sb.size() == 0)) begin
      check("quiet_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic kick(input logic [7:0] dd, input logic [7:0] dv);
    wait_ready();
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv);
    kick(dd, dv);
    wait_quiet();
  endtask

  task automatic wait_strobe(input string tag, input int which, input int nth);
    int n = 0;
    int seen = 0;
    while (seen < nth && n < 100) begin
      @(posedge clk); #1;
      if ((which == 0 && sh) || (which == 1 && sub) || (which == 2 && (rest || qset))) seen++;
      n++;
    end
    if (seen < nth) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #20 rst = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_outs", 32'({done, err, cnt_init, cnt_en, ld, sh, sub, rest, qset}), 32'd0);
    @(posedge clk); #1;

    run_div(8'd100, 8'd7);
    run_div(8'd255, 8'd1);
    run_div(8'd5, 8'd9);
    for (int i = 0; i < 6; i++) run_div(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));

    // start held high: second division begins on the single IDLE cycle after done
    wait_ready();
    dividend = 8'd100;
    divisor  = 8'd7;
    last_gap = -1;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 100 && last_gap < 0; n++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b_gap", 32'(last_gap), 32'd1);
    wait_quiet();

    // start pulse during SUB must not queue a second division
    kick(8'd77, 8'd5);
    wait_strobe("sub_timeout", 1, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_quiet();
    repeat (40) @(posedge clk);
    #1 check("sub_start_ignored", 32'(ready), 32'd1);

    // abort in the TEST of iteration 3
    kick(8'd100, 8'd7);
    wait_strobe("test_timeout", 2, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    repeat (30) @(posedge clk);
    #1 check("abort_idle", 32'(ready), 32'd1);
    run_div(8'd100, 8'd7);

    // watchdog: counter carry suppressed
    co_kill = 1'b1;
    run_div(8'd200, 8'd3);
    co_kill = 1'b0;
    check("err_sticky", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("err_hold", 32'(err), 32'd1);
    kick(8'd9, 8'd2);
    check("err_clear", 32'(err), 32'd0);
    wait_quiet();

    // asynchronous reset between edges while in SHIFT
    kick(8'd100, 8'd7);
    wait_strobe("shift_timeout", 0, 2);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_outs", 32'({done, err, cnt_init, cnt_en, ld, sh, sub, rest, qset}), 32'd0);
    sb.delete();
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("arst_idle", 32'(ready), 32'd1);
    run_div(8'd100, 8'd7);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
